// File: rtl/imm_extend_pipe_pkg.sv
// Shared opcode patterns, immediate format codes and size defaults
// for the ID-stage immediate extractor.
package imm_extend_pipe_pkg;

   localparam int WORD_DEF      = 64;
   localparam int INST_SIZE_DEF = 32;

   typedef enum logic [2:0] {
      IMM_FMT_NONE  = 3'd0,
      IMM_FMT_SHAMT = 3'd1,
      IMM_FMT_ALUI  = 3'd2,
      IMM_FMT_DMEM  = 3'd3,
      IMM_FMT_CBR   = 3'd4,
      IMM_FMT_BR    = 3'd5,
      IMM_FMT_MOVW  = 3'd6
   } imm_fmt_e;

   // Opcodes are matched on inst[31:21]; shorter opcodes use the top bits only
   localparam logic [9:0]  OP_LSLR  = 10'h34D;
   localparam logic [9:0]  OP_ADDI  = 10'h244;
   localparam logic [9:0]  OP_ANDI  = 10'h248;
   localparam logic [9:0]  OP_ORRI  = 10'h2C8;
   localparam logic [9:0]  OP_SUBI  = 10'h344;
   localparam logic [9:0]  OP_EORI  = 10'h348;
   localparam logic [9:0]  OP_SUBIS = 10'h3C4;
   localparam logic [10:0] OP_LDUR  = 11'h7C2;
   localparam logic [10:0] OP_STUR  = 11'h7C0;
   localparam logic [6:0]  OP_CBX   = 7'h5A;
   localparam logic [7:0]  OP_BCOND = 8'h54;
   localparam logic [5:0]  OP_B     = 6'h05;
   localparam logic [5:0]  OP_BL    = 6'h25;
   localparam logic [8:0]  OP_MOVZ  = 9'h1A5;
   localparam logic [8:0]  OP_MOVK  = 9'h1E5;

   function automatic logic is_shamt(input logic [10:0] op);
      return op[10:1] == OP_LSLR;
   endfunction

   function automatic logic is_alui(input logic [10:0] op);
      return (op[10:1] == OP_ADDI) || (op[10:1] == OP_ANDI) ||
             (op[10:1] == OP_ORRI) || (op[10:1] == OP_SUBI) ||
             (op[10:1] == OP_EORI) || (op[10:1] == OP_SUBIS);
   endfunction

   function automatic logic is_dmem(input logic [10:0] op);
      return (op == OP_LDUR) || (op == OP_STUR);
   endfunction

   function automatic logic is_cbr(input logic [10:0] op);
      return (op[10:4] == OP_CBX) || (op[10:3] == OP_BCOND);
   endfunction

   function automatic logic is_br(input logic [10:0] op);
      return (op[10:5] == OP_B) || (op[10:5] == OP_BL);
   endfunction

   function automatic logic is_movw(input logic [10:0] op);
      return (op[10:2] == OP_MOVZ) || (op[10:2] == OP_MOVK);
   endfunction

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// Combinational immediate classifier/extender: inst -> {fmt, imm}.
// Field layout and scaling are selected by parameters.
module imm_decode
   import imm_extend_pipe_pkg::*;
#(
   parameter int WORD          = WORD_DEF,
   parameter int INST_SIZE     = INST_SIZE_DEF,
   parameter int LEGACY_FIELDS = 1,
   parameter int SCALE_BRANCH  = 0,
   parameter int MOV_SHIFT     = 0
) (
   input  logic [INST_SIZE-1:0] inst_i,
   output imm_fmt_e             fmt_o,
   output logic [WORD-1:0]      imm_o
);

   logic [10:0]     op;
   logic [WORD-1:0] ext;

   assign op = inst_i[31:21];

   always_comb begin
      fmt_o = IMM_FMT_NONE;
      ext   = WORD'(inst_i);
      unique case (1'b1)
         is_shamt(op): begin
            fmt_o = IMM_FMT_SHAMT;
            ext   = WORD'($signed(inst_i[15:10]));
         end
         is_alui(op): begin
            fmt_o = IMM_FMT_ALUI;
            if (LEGACY_FIELDS != 0)
               ext = WORD'($signed(inst_i[20:10]));
            else
               ext = WORD'(inst_i[21:10]);
         end
         is_dmem(op): begin
            fmt_o = IMM_FMT_DMEM;
            ext   = WORD'($signed(inst_i[20:12]));
         end
         is_cbr(op): begin
            fmt_o = IMM_FMT_CBR;
            if (LEGACY_FIELDS != 0)
               ext = WORD'($signed(inst_i[20:5]));
            else
               ext = WORD'($signed(inst_i[23:5]));
         end
         is_br(op): begin
            fmt_o = IMM_FMT_BR;
            if (LEGACY_FIELDS != 0)
               ext = WORD'($signed(inst_i[20:0]));
            else
               ext = WORD'($signed(inst_i[25:0]));
         end
         is_movw(op): begin
            fmt_o = IMM_FMT_MOVW;
            ext   = WORD'(inst_i[20:5]);
            if (MOV_SHIFT != 0)
               ext = ext << {inst_i[22:21], 4'b0000};
         end
         default: ;
      endcase
   end

   // Branch scaling happens after extension so the sign is kept
   always_comb begin
      imm_o = ext;
      if ((SCALE_BRANCH != 0) &&
          ((fmt_o == IMM_FMT_CBR) || (fmt_o == IMM_FMT_BR)))
         imm_o = ext << 2;
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extractor with a 2-entry skid buffer.
// Decode happens on the input side; buffers hold decoded entries.
module imm_extend_pipe
   import imm_extend_pipe_pkg::*;
#(
   parameter int WORD          = WORD_DEF,
   parameter int INST_SIZE     = INST_SIZE_DEF,
   parameter int LEGACY_FIELDS = 1,
   parameter int SCALE_BRANCH  = 0,
   parameter int MOV_SHIFT     = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INST_SIZE-1:0] in_inst,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD-1:0]      out_imm,
   output logic [2:0]           out_fmt,
   output logic [INST_SIZE-1:0] out_inst
);

   if (INST_SIZE != 32) begin : g_bad_inst
      $error("imm_extend_pipe: INST_SIZE must be 32");
   end
   if ((WORD < 32) || (WORD > 128)) begin : g_bad_word
      $error("imm_extend_pipe: WORD must be 32..128");
   end

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [WORD-1:0]      imm;
      imm_fmt_e             fmt;
      logic [INST_SIZE-1:0] inst;
   } entry_t;

   state_e   state_q;
   entry_t   out_q;
   entry_t   skid_q;
   entry_t   dec_d;
   imm_fmt_e dec_fmt;
   logic     in_hs;

   imm_decode #(
      .WORD          (WORD),
      .INST_SIZE     (INST_SIZE),
      .LEGACY_FIELDS (LEGACY_FIELDS),
      .SCALE_BRANCH  (SCALE_BRANCH),
      .MOV_SHIFT     (MOV_SHIFT)
   ) u_dec (
      .inst_i (in_inst),
      .fmt_o  (dec_fmt),
      .imm_o  (dec_d.imm)
   );

   assign dec_d.fmt  = dec_fmt;
   assign dec_d.inst = in_inst;

   assign in_ready = !rst && (state_q != S_FULL);
   assign in_hs    = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         out_q   <= '0;
      end else if (flush) begin
         state_q <= S_EMPTY;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (in_hs) begin
                  out_q   <= dec_d;
                  state_q <= S_ONE;
               end
            end
            S_ONE: begin
               if (in_hs && out_ready) begin
                  out_q <= dec_d;
               end else if (in_hs) begin
                  skid_q  <= dec_d;
                  state_q <= S_FULL;
               end else if (out_ready) begin
                  state_q <= S_EMPTY;
               end
            end
            S_FULL: begin
               if (out_ready) begin
                  out_q   <= skid_q;
                  state_q <= S_ONE;
               end
            end
            default: state_q <= S_EMPTY;
         endcase
      end
   end

   assign out_valid = (state_q != S_EMPTY);
   assign out_imm   = out_q.imm;
   assign out_fmt   = out_q.fmt;
   assign out_inst  = out_q.inst;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomised bench for imm_extend_pipe: two parameter sets driven in
// lockstep and compared against a queue-based reference model.
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_inst;

   logic        in_ready_a, out_valid_a;
   logic [63:0] out_imm_a;
   logic [2:0]  out_fmt_a;
   logic [31:0] out_inst_a;

   logic        in_ready_b, out_valid_b;
   logic [63:0] out_imm_b;
   logic [2:0]  out_fmt_b;
   logic [31:0] out_inst_b;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   imm_extend_pipe #(
      .WORD(64), .INST_SIZE(32),
      .LEGACY_FIELDS(1), .SCALE_BRANCH(0), .MOV_SHIFT(0)
   ) dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_inst(in_inst),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_inst(out_inst_a)
   );

   imm_extend_pipe #(
      .WORD(64), .INST_SIZE(32),
      .LEGACY_FIELDS(0), .SCALE_BRANCH(1), .MOV_SHIFT(1)
   ) dut_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_inst(in_inst),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_inst(out_inst_b)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
   endtask

   function automatic int ref_fmt(input logic [10:0] op);
      if (op inside {[11'h69A:11'h69B]}) return 1;
      if (op inside {[11'h488:11'h489], [11'h490:11'h491],
                     [11'h590:11'h591], [11'h688:11'h689],
                     [11'h690:11'h691], [11'h788:11'h789]}) return 2;
      if (op inside {11'h7C0, 11'h7C2}) return 3;
      if (op inside {[11'h5A0:11'h5AF], [11'h2A0:11'h2A7]}) return 4;
      if (op inside {[11'h0A0:11'h0BF], [11'h4A0:11'h4BF]}) return 5;
      if (op inside {[11'h694:11'h697], [11'h794:11'h797]}) return 6;
      return 0;
   endfunction

   function automatic longint sx(input longint raw, input int n);
      if (raw >= (longint'(1) << (n - 1))) return raw - (longint'(1) << n);
      return raw;
   endfunction

   function automatic logic [63:0] ref_imm(input logic [31:0] i,
                                           input bit legacy,
                                           input bit scale,
                                           input bit movsh);
      longint v;
      int     f;
      f = ref_fmt(i[31:21]);
      case (f)
         1: v = sx(longint'(i[15:10]), 6);
         2: v = legacy ? sx(longint'(i[20:10]), 11) : longint'(i[21:10]);
         3: v = sx(longint'(i[20:12]), 9);
         4: v = legacy ? sx(longint'(i[20:5]), 16) : sx(longint'(i[23:5]), 19);
         5: v = legacy ? sx(longint'(i[20:0]), 21) : sx(longint'(i[25:0]), 26);
         6: begin
            v = longint'(i[20:5]);
            if (movsh) v = v * (longint'(1) << (16 * int'(i[22:21])));
         end
         default: v = longint'(i);
      endcase
      if (scale && (f == 4 || f == 5)) v = v * 4;
      return 64'(v);
   endfunction

   typedef struct {
      logic [31:0] inst;
      logic [2:0]  fmt;
      logic [63:0] imm_a;
      logic [63:0] imm_b;
   } exp_t;

   exp_t q[$];

   logic [10:0] rng_lo [16] = '{11'h69A, 11'h488, 11'h490, 11'h590,
                                11'h688, 11'h690, 11'h788, 11'h7C0,
                                11'h7C2, 11'h5A0, 11'h2A0, 11'h0A0,
                                11'h4A0, 11'h694, 11'h794, 11'h5A8};
   logic [10:0] rng_hi [16] = '{11'h69B, 11'h489, 11'h491, 11'h591,
                                11'h689, 11'h691, 11'h789, 11'h7C0,
                                11'h7C2, 11'h5A7, 11'h2A7, 11'h0BF,
                                11'h4BF, 11'h697, 11'h797, 11'h5AF};

   function automatic logic [31:0] gen();
      logic [31:0] r;
      int          k;
      r = $urandom;
      k = $urandom_range(0, 16);
      if (k < 16)
         r[31:21] = 11'($urandom_range(int'(rng_lo[k]), int'(rng_hi[k])));
      return r;
   endfunction

   // Scoreboard: checks the current state, then applies the coming edge
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         chk("rdy_in_rst_a", 64'(in_ready_a), 64'(0));
         chk("rdy_in_rst_b", 64'(in_ready_b), 64'(0));
         q.delete();
      end else begin
         chk("in_ready_a", 64'(in_ready_a), 64'(q.size() < 2));
         chk("in_ready_b", 64'(in_ready_b), 64'(q.size() < 2));
         chk("out_valid_a", 64'(out_valid_a), 64'(q.size() != 0));
         chk("out_valid_b", 64'(out_valid_b), 64'(q.size() != 0));
         if (q.size() != 0) begin
            chk("inst_a", 64'(out_inst_a), 64'(q[0].inst));
            chk("inst_b", 64'(out_inst_b), 64'(q[0].inst));
            chk("fmt_a", 64'(out_fmt_a), 64'(q[0].fmt));
            chk("fmt_b", 64'(out_fmt_b), 64'(q[0].fmt));
            chk("imm_a", out_imm_a, q[0].imm_a);
            chk("imm_b", out_imm_b, q[0].imm_b);
         end
         if (flush) begin
            q.delete();
         end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && in_ready_a) begin
               e.inst  = in_inst;
               e.fmt   = 3'(ref_fmt(in_inst[31:21]));
               e.imm_a = ref_imm(in_inst, 1'b1, 1'b0, 1'b0);
               e.imm_b = ref_imm(in_inst, 1'b0, 1'b1, 1'b1);
               q.push_back(e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] i0, i1, i2, i5, i9;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; in_inst = '0;
      step();
      chk("rst_ready", 64'(in_ready_a), 64'(0));
      chk("rst_valid", 64'(out_valid_a), 64'(0));
      chk("rst_imm", out_imm_a, 64'(0));
      chk("rst_fmt", 64'(out_fmt_a), 64'(0));
      chk("rst_inst", 64'(out_inst_a), 64'(0));
      rst = 1'b0;
      step();
      chk("post_rst_ready", 64'(in_ready_a), 64'(1));

      // LDUR with imm9 = -8
      in_inst = {11'h7C2, 9'h1F8, 2'b00, 5'd1, 5'd2};
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("ldur_valid", 64'(out_valid_a), 64'(1));
      chk("ldur_fmt", 64'(out_fmt_a), 64'(3));
      chk("ldur_imm", out_imm_a, 64'hFFFF_FFFF_FFFF_FFF8);
      step();

      in_inst = {6'b000101, 26'h3FFFFFF};
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("b_fmt", 64'(out_fmt_b), 64'(5));
      chk("b_imm_arch", out_imm_b, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("b_imm_legacy", out_imm_a, 64'hFFFF_FFFF_FFFF_FFFF);
      step();

      in_inst = {9'b110100101, 2'd2, 16'hABCD, 5'd3};
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("movz_fmt", 64'(out_fmt_b), 64'(6));
      chk("movz_imm_sh", out_imm_b, 64'h0000_ABCD_0000_0000);
      chk("movz_imm_nosh", out_imm_a, 64'h0000_0000_0000_ABCD);
      step();

      // Backpressure: three stalled cycles then drain
      i0 = gen(); i1 = gen(); i2 = gen();
      out_ready = 1'b0; in_valid = 1'b1;
      in_inst = i0; step();
      in_inst = i1; step();
      chk("bp_full_ready", 64'(in_ready_a), 64'(0));
      in_inst = i2; step();
      chk("bp_hold_ready", 64'(in_ready_a), 64'(0));
      chk("bp_hold_i0", 64'(out_inst_a), 64'(i0));
      out_ready = 1'b1; step();
      chk("bp_out_i1", 64'(out_inst_a), 64'(i1));
      step();
      in_valid = 1'b0;
      chk("bp_out_i2", 64'(out_inst_a), 64'(i2));
      step();
      chk("bp_empty", 64'(out_valid_a), 64'(0));

      // Flush while FULL with a live input
      out_ready = 1'b0; in_valid = 1'b1;
      in_inst = gen(); step();
      in_inst = gen(); step();
      i5 = gen();
      in_inst = i5; flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", 64'(out_valid_a), 64'(0));
      chk("fl_ready", 64'(in_ready_a), 64'(1));
      out_ready = 1'b1; step(); step();
      chk("fl_dropped", 64'(out_valid_a), 64'(0));

      // Reset while FULL
      out_ready = 1'b0; in_valid = 1'b1;
      in_inst = gen(); step();
      in_inst = gen(); step();
      rst = 1'b1; in_inst = gen();
      #1;
      chk("rstf_ready", 64'(in_ready_a), 64'(0));
      step();
      chk("rstf_valid", 64'(out_valid_a), 64'(0));
      chk("rstf_imm", out_imm_a, 64'(0));
      chk("rstf_inst", 64'(out_inst_a), 64'(0));
      rst = 1'b0;
      i9 = gen();
      in_inst = i9; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("rstf_first_v", 64'(out_valid_a), 64'(1));
      chk("rstf_first_i", 64'(out_inst_a), 64'(i9));
      step();

      for (int n = 0; n < 3000; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_inst   = gen();
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         rst       = ($urandom_range(0, 199) == 0);
         step();
      end

      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
